// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the two-requester APB master.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_GPIO = 2'b01;
    localparam logic [1:0] SEL_UART = 2'b10;

    localparam logic [2:0] PPROT_DEFAULT = 3'b000;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant, pointer flips away from the winner.
module rr_arbiter2
    import apb_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       adv_i,
    output logic [1:0] gnt_o,
    output logic       gnt_idx_o
);

    logic prio_q;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        gnt_idx_o = prio_q;
        if (req_i == 2'b01) begin
            gnt_idx_o = 1'b0;
        end else if (req_i == 2'b10) begin
            gnt_idx_o = 1'b1;
        end
        gnt_o = (req_i != 2'b00) ? onehot2(gnt_idx_o) : 2'b00;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q <= 1'b0;
        end else if (adv_i && (req_i != 2'b00)) begin
            prio_q <= ~gnt_idx_o;
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Two-requester APB master with round-robin arbitration and GPIO/UART decode.
// Optional ACCESS-phase watchdog enabled by defining APB_TIMEOUT_EN.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int SEL_BIT     = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic [1:0]          req_valid,
    input  logic [1:0]          req_write,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          req_ready,
    output logic [1:0]          rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                busy,
    output logic [ADDR_W-1:0]   PADDR,
    output logic [DATA_W-1:0]   PWDATA,
    output logic                PWRITE,
    output logic [1:0]          PSEL,
    output logic                PENABLE,
    output logic [2:0]          PPROT,
    input  logic [DATA_W-1:0]   PRDATA,
    input  logic                PREADY,
    input  logic                PSLVERR
);

    apb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic [1:0]        sel_q, sel_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              arb_req;
    logic [1:0]        arb_gnt;
    logic              arb_idx;
    logic [ADDR_W-1:0] win_addr;
    logic              win_unmapped;
    logic [1:0]        win_sel;
    logic              tmo_hit;

    assign arb_req = (state_q == IDLE) && (req_valid != 2'b00);

    rr_arbiter2 u_arb (
        .clk_i     (PCLK),
        .rst_i     (PRESET),
        .req_i     (req_valid),
        .adv_i     (arb_req),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx)
    );

    assign win_addr     = arb_idx ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
    assign win_unmapped = |win_addr[ADDR_W-1:SEL_BIT+1];
    assign win_sel      = win_unmapped      ? SEL_NONE :
                          win_addr[SEL_BIT] ? SEL_UART : SEL_GPIO;

`ifdef APB_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // The counter holds completed wait cycles; the one about to complete is the limit-th.
    assign tmo_hit = (state_q == ACCESS) && !PREADY && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    always_comb begin
        tmo_d = tmo_q;
        if (state_q == SETUP) begin
            tmo_d = '0;
        end else if ((state_q == ACCESS) && !PREADY) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (arb_req) begin
                    owner_d = arb_idx;
                    addr_d  = win_addr;
                    wdata_d = arb_idx ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
                    write_d = req_write[arb_idx];
                    sel_d   = win_sel;
                    rdata_d = '0;
                    err_d   = win_unmapped;
                    // Unmapped addresses never touch the bus.
                    state_d = win_unmapped ? RESP : SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (PREADY) begin
                    rdata_d = (write_q || PSLVERR) ? '0 : PRDATA;
                    err_d   = PSLVERR;
                    state_d = RESP;
                end else if (tmo_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            sel_q   <= SEL_NONE;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Accept pulse is gated by reset so nothing is granted while reset is held.
    assign req_ready = (arb_req && !PRESET) ? arb_gnt : 2'b00;
    assign rsp_valid = (state_q == RESP) ? onehot2(owner_q) : 2'b00;
    assign rsp_rdata = (state_q == RESP) ? rdata_q : '0;
    assign rsp_err   = (state_q == RESP) && err_q;
    assign busy      = (state_q != IDLE);

    assign PSEL    = ((state_q == SETUP) || (state_q == ACCESS)) ? sel_q : SEL_NONE;
    assign PENABLE = (state_q == ACCESS);
    assign PADDR   = addr_q;
    assign PWDATA  = wdata_q;
    assign PWRITE  = write_q;
    assign PPROT   = PPROT_DEFAULT;

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Two-requester APB master that arbitrates access to the shared APB bus serving the GPIO and UART peripherals. It runs the APB SETUP/ACCESS protocol, decodes the address to a one-hot `PSEL[1:0]` (GPIO/UART), absorbs peripheral wait states, and returns read data and error status to the granted requester. It sits between on-chip bus masters (for example a CPU port and a DMA/test port) and the `PSEL`/`PENABLE`/`PREADY` bus.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `SEL_BIT`, 8, address bit selecting peripheral: 0 = GPIO, 1 = UART
- `TIMEOUT_CYC`, 16, maximum ACCESS cycles before abort; used only with `APB_TIMEOUT_EN`
- `PCLK`  in  1  clock; all logic on rising edge
- `PRESET`  in  1  synchronous reset, active-high
- `req_valid`  in  2  per-requester request; held stable until accepted
- `req_write`  in  2  per-requester: 1 = write, 0 = read
- `req_addr`  in  2*ADDR_W  per-requester address; requester i in slice i
- `req_wdata`  in  2*DATA_W  per-requester write data
- `req_ready`  out  2  one-cycle accept pulse to the granted requester
- `rsp_valid`  out  2  one-cycle completion pulse to the owning requester
- `rsp_rdata`  out  DATA_W  read data, valid with `rsp_valid`; 0 for writes and errors
- `rsp_err`  out  1  error flag, valid with `rsp_valid`
- `busy`  out  1  high whenever the FSM is not IDLE
- `PADDR`  out  ADDR_W  APB address
- `PWDATA`  out  DATA_W  APB write data
- `PWRITE`  out  1  APB direction
- `PSEL`  out  2  one-hot select: 01 = GPIO, 10 = UART
- `PENABLE`  out  1  APB access phase
- `PPROT`  out  3  constant 3'b000
- `PRDATA`  in  DATA_W  APB read data
- `PREADY`  in  1  APB ready
- `PSLVERR`  in  1  APB slave error

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- **IDLE:** if any `req_valid` is high, a round-robin arbiter picks one requester.
  - The priority pointer moves to the other requester after each grant. After reset, requester 0 has priority.
  - The chosen requester gets a `req_ready` pulse.
  - The address, data and direction are latched and the FSM moves to SETUP.
  - If both requesters are valid, exactly one is granted. The loser stays pending and wins the next arbitration.
- **Address decode:** uses the latched address.
  - Decode covers `addr[ADDR_W-1:SEL_BIT+1]`; any nonzero bit there means unmapped.
  - Unmapped address: no APB cycle is issued (`PSEL` stays 00). The FSM goes directly to RESP with `rsp_err`=1.
- **SETUP:** `PSEL` = decoded one-hot, `PENABLE`=0, `PADDR`/`PWDATA`/`PWRITE` driven. Always lasts exactly one cycle, then the FSM moves to ACCESS.
- **ACCESS:** `PENABLE`=1. `PSEL`, `PADDR`, `PWDATA` and `PWRITE` are held unchanged.
  - Stays in ACCESS while `PREADY`=0 (wait states).
  - On `PREADY`=1, samples `PRDATA` (reads only) and `PSLVERR`, then moves to RESP.
- **RESP:** `PSEL`=00, `PENABLE`=0.
  - Pulses `rsp_valid[owner]` with `rsp_rdata` and `rsp_err`.
  - On a write, `rsp_rdata` = 0.
  - Returns to IDLE.
- **Reset values:** all outputs are 0 (`PSEL`=00, `PENABLE`=0, `req_ready`=00, `rsp_valid`=00, `busy`=0). State = IDLE, priority = requester 0.
- **Reset mid-transfer:** the bus is released on the next edge, no response is delivered, and the pending request is dropped. Requesters must reissue.

## Timing
- Accept in cycle N (IDLE, `req_ready`), SETUP N+1, ACCESS N+2.
- Zero-wait-state transfer: `PREADY`=1 at N+2 gives `rsp_valid` at N+3. The next accept is at N+4.
  - Total: 4 cycles per transfer. Each wait state adds 1 cycle.
- Unmapped address: `rsp_valid` arrives at N+1.
- `PRDATA` and `PSLVERR` are sampled only in the ACCESS cycle where `PREADY`=1. Both are ignored at all other times.
- `req_valid` dropping before `req_ready` is a requester protocol violation. Behaviour in that case is undefined.

## Configuration
- `APB_TIMEOUT_EN` defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with `PREADY`=0.
  - When the counter reaches `TIMEOUT_CYC`, the FSM moves to RESP with `rsp_err`=1 and `rsp_rdata`=0. `PSEL` and `PENABLE` drop on the same edge.
  - `PREADY`=1 in the same cycle the limit is reached wins, and the transfer completes normally.
- `APB_TIMEOUT_EN` undefined: no counter. ACCESS waits indefinitely for `PREADY`.

## Structure
- Package `apb_arb_pkg` holds:
  - the state enum (IDLE/SETUP/ACCESS/RESP);
  - PSEL constants `SEL_NONE`=2'b00, `SEL_GPIO`=2'b01, `SEL_UART`=2'b10;
  - `PPROT_DEFAULT`=3'b000.
- One sub-module: `rr_arbiter2`, a 2-way round-robin grant. It has a priority pointer, with update on grant, and a one-hot grant output.

## Test plan
- Requester 0 writes 0x0F to addr 0x02 with `PREADY` tied 1 -> `PSEL`=01 for 2 cycles, `PENABLE` high in the 2nd; `rsp_valid`=01 and `rsp_err`=0 at N+3.
- Requester 1 reads addr 0x100 with `PREADY` low for 3 cycles and `PRDATA`=0xA5 -> `PSEL`=10, ACCESS lasts 4 cycles with address/control stable; `rsp_rdata`=0xA5 at N+6.
- Both requesters valid from reset -> grants are 0,1,0,1; no `req_ready` overlap; each request receives exactly one `rsp_valid`.
- Read addr 0x400 -> `PSEL` never asserted; `rsp_err`=1 at N+1.
- `PSLVERR`=1 with `PREADY` on a GPIO write -> `rsp_err`=1, `rsp_rdata`=0.
- With `APB_TIMEOUT_EN` and `TIMEOUT_CYC`=16, `PREADY` stuck low -> `PENABLE` drops after 16 ACCESS cycles, `rsp_err`=1. Asserting `PRESET` during ACCESS -> all outputs 0 next cycle, no `rsp_valid`.
